// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: memory-mapped bridge between the CPU data bus and the UART byte handshake.
// CPU writes queue in a TX FIFO drained by a small FSM; RX bytes land in a holding register.
module uart_bus_bridge #(
  parameter logic [31:0] BASE_ADDR  = 32'h40000018,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned PTR_W      = 3
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  output logic [7:0]  tx_data,
  output logic        tx_send,
  input  logic        tx_status,
  input  logic        rx_status,
  input  logic [7:0]  rx_data
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} tx_state_e;

  localparam logic [PTR_W:0] DEPTH = (PTR_W+1)'(FIFO_DEPTH);

  tx_state_e        state_q, state_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic [7:0]       tx_data_q;
  logic [7:0]       rx_buf_q;
  logic             rx_valid_q, overrun_q, tx_drop_q;
  logic             rx_irq_en_q, tx_irq_en_q, irq_q;

  logic sel_tx, sel_rx, sel_st;
  logic fifo_full, fifo_empty, tx_busy;
  logic push_req, push, pop, rx_rd, st_wr;
  logic unused_wdata;

  assign sel_tx     = (addr == BASE_ADDR);
  assign sel_rx     = (addr == BASE_ADDR + 32'd4);
  assign sel_st     = (addr == BASE_ADDR + 32'd8);
  assign fifo_full  = (count_q == DEPTH);
  assign fifo_empty = (count_q == '0);
  assign tx_busy    = (state_q != IDLE);
  // Fullness is judged before any same-cycle pop, so a push into a full FIFO is always dropped.
  assign push_req   = wr & sel_tx;
  assign push       = push_req & ~fifo_full;
  assign rx_rd      = rd & sel_rx;
  assign st_wr      = wr & sel_st;
  assign unused_wdata = ^wdata[31:8];

  assign tx_data = tx_data_q;
  assign tx_send = (state_q == SEND);
  assign irq     = irq_q;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && tx_status) begin
          pop     = 1'b1;
          state_d = SEND;
        end
      end
      SEND:      state_d = WAIT_BUSY;
      WAIT_BUSY: if (!tx_status) state_d = WAIT_DONE;
      WAIT_DONE: if (tx_status) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    rdata = '0;
    if (sel_rx) begin
      rdata = {24'b0, rx_buf_q};
    end else if (sel_st) begin
      rdata = {24'b0, tx_irq_en_q, rx_irq_en_q, tx_drop_q, overrun_q,
               tx_busy, fifo_empty, fifo_full, rx_valid_q};
    end
  end

  always_ff @(posedge sysclk) begin
    if (push) mem_q[wr_ptr_q] <= wdata[7:0];
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      tx_data_q <= '0;
      tx_drop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + PTR_W'(1);
        tx_data_q <= mem_q[rd_ptr_q];
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
      if (push_req && fifo_full) tx_drop_q <= 1'b1;
      else if (st_wr && wdata[5]) tx_drop_q <= 1'b0;
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      rx_buf_q    <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      rx_irq_en_q <= 1'b0;
      tx_irq_en_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      if (rx_status) begin
        rx_buf_q   <= rx_data;
        rx_valid_q <= 1'b1;
      end else if (rx_rd) begin
        rx_valid_q <= 1'b0;
      end
      // A fresh overrun event takes priority over a same-cycle software clear.
      if (rx_status && rx_valid_q && !rx_rd) overrun_q <= 1'b1;
      else if (st_wr && wdata[4]) overrun_q <= 1'b0;
      if (st_wr) begin
        rx_irq_en_q <= wdata[6];
        tx_irq_en_q <= wdata[7];
      end
      irq_q <= (rx_irq_en_q & rx_valid_q) | (tx_irq_en_q & fifo_empty & ~tx_busy);
    end
  end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Self-checking bench for uart_bus_bridge: directed sequence with random bytes,
// checked against a queue-based register model.
module tb_uart_bus_bridge;
  localparam logic [31:0] BASE = 32'h40000018;
  localparam logic [31:0] A_TX = BASE;
  localparam logic [31:0] A_RX = BASE + 32'd4;
  localparam logic [31:0] A_ST = BASE + 32'd8;
  localparam int DEPTH = 8;

  logic        sysclk = 1'b0;
  logic        reset = 1'b0;
  logic        rd = 1'b0, wr = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        irq, tx_send;
  logic [7:0]  tx_data;
  logic        tx_status = 1'b0, rx_status = 1'b0;
  logic [7:0]  rx_data = '0;

  int total = 0;
  int bad = 0;

  logic [7:0] tx_q[$];
  bit m_drop, m_over, m_rxv, m_rie, m_tie;
  logic [7:0] m_rxbuf;

  uart_bus_bridge #(.BASE_ADDR(BASE), .FIFO_DEPTH(8), .PTR_W(3)) dut (
    .sysclk(sysclk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .irq(irq), .tx_data(tx_data), .tx_send(tx_send),
    .tx_status(tx_status), .rx_status(rx_status), .rx_data(rx_data)
  );

  always #5 sysclk = ~sysclk;

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status(input bit busy);
    return {24'b0, m_tie, m_rie, m_drop, m_over, busy,
            tx_q.size() == 0, tx_q.size() == DEPTH, m_rxv};
  endfunction

  task automatic model_reset();
    tx_q.delete();
    m_drop = 0; m_over = 0; m_rxv = 0; m_rie = 0; m_tie = 0; m_rxbuf = '0;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr = 1'b1;
    tick();
    wr = 1'b0;
    if (a == A_TX) begin
      if (tx_q.size() < DEPTH) tx_q.push_back(d[7:0]);
      else m_drop = 1;
    end else if (a == A_ST) begin
      m_rie = d[6]; m_tie = d[7];
      if (d[4]) m_over = 0;
      if (d[5]) m_drop = 0;
    end
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    addr = a; rd = 1'b1;
    #1 d = rdata;
    tick();
    rd = 1'b0;
    if (a == A_RX) m_rxv = 0;
  endtask

  task automatic peek(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    #1 d = rdata;
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    rx_data = b; rx_status = 1'b1;
    tick();
    rx_status = 1'b0;
    if (m_rxv) m_over = 1;
    m_rxv = 1; m_rxbuf = b;
  endtask

  // UART sender model: busy 160 cycles after a send request, idle again 10 baud later.
  task automatic uart_run();
    logic [7:0] b;
    bit ok;
    int n;
    while (tx_q.size() > 0) begin
      n = 0;
      while (tx_send !== 1'b1 && n < 20) begin tick(); n++; end
      chk("send_seen", {31'b0, tx_send}, 32'd1);
      if (tx_send !== 1'b1) begin tx_q.delete(); return; end
      b = tx_q.pop_front();
      chk("tx_data", {24'b0, tx_data}, {24'b0, b});
      tick();
      chk("send_1cyc", {31'b0, tx_send}, 32'd0);
      addr = A_ST;
      #1 chk("busy_bit", {31'b0, rdata[3]}, 32'd1);
      ok = 1;
      for (int i = 0; i < 159; i++) begin
        tick(); ok &= (tx_data === b) && (tx_send === 1'b0);
      end
      tx_status = 1'b0;
      for (int i = 0; i < 1600; i++) begin
        tick(); ok &= (tx_data === b) && (tx_send === 1'b0);
      end
      tx_status = 1'b1;
      chk("tx_hold", {31'b0, ok}, 32'd1);
    end
  endtask

  initial begin
    logic [31:0] s;
    logic [7:0] b, b2;
    bit ok;
    int n;

    model_reset();
    repeat (3) tick();
    reset = 1'b1;
    tick();
    peek(A_ST, s);
    chk("rst_status", s, 32'h4);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    chk("rst_send", {31'b0, tx_send}, 32'd0);
    chk("rst_txdata", {24'b0, tx_data}, 32'd0);

    bus_wr(A_TX, 32'h41); bus_wr(A_TX, 32'h42); bus_wr(A_TX, 32'h43);
    peek(A_ST, s);
    chk("q3_status", s, exp_status(0));
    tx_status = 1'b1;
    uart_run();
    repeat (3) tick();
    peek(A_ST, s);
    chk("drained_status", s, 32'h4);

    tx_status = 1'b0;
    for (int i = 0; i < 9; i++) bus_wr(A_TX, $urandom);
    peek(A_ST, s);
    chk("full_status", s, 32'h22);
    bus_wr(A_ST, 32'h20);
    peek(A_ST, s);
    chk("drop_clear", s, 32'h02);
    tx_status = 1'b1;
    bus_wr(A_TX, $urandom);
    peek(A_ST, s);
    chk("full_pop_push_drop", {31'b0, s[5]}, 32'd1);
    uart_run();
    repeat (3) tick();
    peek(A_ST, s);
    chk("wrap_status", s, exp_status(0));
    bus_wr(A_ST, 32'h20);

    rx_pulse(8'h5A);
    peek(A_ST, s);
    chk("rx_valid_set", s, 32'h05);
    bus_rd(A_RX, s);
    chk("rx_read", s, 32'h5A);
    peek(A_ST, s);
    chk("rx_valid_clr", s, 32'h04);
    rx_pulse(8'h11); rx_pulse(8'h22);
    peek(A_ST, s);
    chk("overrun_status", s, 32'h15);
    bus_rd(A_RX, s);
    chk("overrun_buf", s, 32'h22);
    bus_wr(A_ST, 32'h10);

    repeat (4) begin
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) rx_pulse(8'($urandom));
      peek(A_ST, s);
      chk("rnd_rx_status", s, exp_status(0));
      bus_rd(A_RX, s);
      chk("rnd_rx_buf", s, {24'b0, m_rxbuf});
      bus_wr(A_ST, 32'h10);
    end

    b = 8'($urandom); b2 = 8'($urandom);
    rx_pulse(b);
    rx_data = b2; rx_status = 1'b1; addr = A_RX; rd = 1'b1;
    #1 s = rdata;
    chk("coinc_old", s, {24'b0, b});
    tick();
    rd = 1'b0; rx_status = 1'b0;
    m_rxbuf = b2; m_rxv = 1;
    peek(A_ST, s);
    chk("coinc_status", s, 32'h05);
    bus_rd(A_RX, s);
    chk("coinc_new", s, {24'b0, b2});

    bus_wr(A_ST, 32'h50);
    tick();
    chk("irq_off", {31'b0, irq}, 32'd0);
    rx_pulse(8'($urandom));
    chk("irq_lag", {31'b0, irq}, 32'd0);
    tick();
    chk("irq_rx", {31'b0, irq}, 32'd1);
    bus_rd(A_RX, s);
    chk("irq_hold", {31'b0, irq}, 32'd1);
    tick();
    chk("irq_rx_clr", {31'b0, irq}, 32'd0);
    bus_wr(A_ST, 32'h80);
    chk("irq_tx_lag", {31'b0, irq}, 32'd0);
    tick();
    chk("irq_tx", {31'b0, irq}, 32'd1);

    bus_wr(A_ST, 32'h40);
    tx_status = 1'b0;
    for (int i = 0; i < 4; i++) bus_wr(A_TX, $urandom);
    tx_status = 1'b1;
    n = 0;
    while (tx_send !== 1'b1 && n < 20) begin tick(); n++; end
    chk("rst_pre_send", {31'b0, tx_send}, 32'd1);
    tick();
    tx_status = 1'b0;
    repeat (20) tick();
    peek(A_ST, s);
    chk("rst_pre_busy", {31'b0, s[3]}, 32'd1);
    rx_pulse(8'($urandom));
    tick();
    chk("rst_pre_irq", {31'b0, irq}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_txdata", {24'b0, tx_data}, 32'd0);
    chk("mid_rst_send", {31'b0, tx_send}, 32'd0);
    chk("mid_rst_irq", {31'b0, irq}, 32'd0);
    chk("mid_rst_status", rdata, 32'h4);
    model_reset();
    tx_status = 1'b1;
    #3 reset = 1'b1;
    ok = 1;
    for (int i = 0; i < 50; i++) begin tick(); ok &= (tx_send === 1'b0); end
    chk("post_rst_nosend", {31'b0, ok}, 32'd1);
    peek(A_ST, s);
    chk("post_rst_status", s, exp_status(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
